// File: rtl/dlx_ctrl_pkg.sv
// rtl/dlx_ctrl_pkg.sv - DLX control bundle, opcode/func/ALU codes and the decode function
package dlx_ctrl_pkg;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       mem2reg;
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       extop;
        logic [1:0] fpoint;
        logic [3:0] aluctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_bundle_t;

    typedef enum logic {IDLE, MUL_WAIT} mul_state_t;

    localparam logic [5:0] OP_RTYPE = 6'd0,  OP_FTYPE = 6'd1,  OP_J     = 6'd2,  OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQZ  = 6'd4,  OP_BNEZ  = 6'd5,  OP_ADDI  = 6'd8,  OP_ADDUI = 6'd9;
    localparam logic [5:0] OP_SUBI  = 6'd10, OP_SUBUI = 6'd11, OP_ANDI  = 6'd12, OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14, OP_LHI   = 6'd15, OP_SLLI  = 6'd20, OP_SRLI  = 6'd22;
    localparam logic [5:0] OP_SRAI  = 6'd23, OP_SEQI  = 6'd24, OP_SNEI  = 6'd25, OP_SLTI  = 6'd26;
    localparam logic [5:0] OP_SGTI  = 6'd27, OP_SLEI  = 6'd28, OP_SGEI  = 6'd29, OP_LB    = 6'd32;
    localparam logic [5:0] OP_LH    = 6'd33, OP_LF    = 6'd34, OP_LW    = 6'd35, OP_LBU   = 6'd36;
    localparam logic [5:0] OP_LHU   = 6'd37, OP_SB    = 6'd40, OP_SH    = 6'd41, OP_SW    = 6'd43;

    localparam logic [10:0] FN_SLL  = 11'd4,  FN_SRL  = 11'd6,  FN_SRA     = 11'd7,  FN_MULT    = 11'd14;
    localparam logic [10:0] FN_NOP  = 11'd21, FN_MULTU = 11'd22, FN_ADD    = 11'd32, FN_ADDU    = 11'd33;
    localparam logic [10:0] FN_SUB  = 11'd34, FN_SUBU = 11'd35, FN_AND     = 11'd36, FN_OR      = 11'd37;
    localparam logic [10:0] FN_XOR  = 11'd38, FN_SEQ  = 11'd40, FN_SNE     = 11'd41, FN_SLT     = 11'd42;
    localparam logic [10:0] FN_SGT  = 11'd43, FN_SLE  = 11'd44, FN_SGE     = 11'd45, FN_MOVFP2I = 11'd52;
    localparam logic [10:0] FN_MOVI2FP = 11'd53;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_XOR = 4'b0010, ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100, ALU_MUL = 4'b0101, ALU_SEQ = 4'b0110, ALU_SNE = 4'b0111;
    localparam logic [3:0] ALU_SGE = 4'b1000, ALU_SGT = 4'b1001, ALU_SLT = 4'b1010, ALU_SLE = 4'b1011;
    localparam logic [3:0] ALU_SLL = 4'b1100, ALU_SRL = 4'b1101, ALU_SRA = 4'b1110;

    localparam logic [1:0] FP_NONE = 2'b00, FP_F2I = 2'b01, FP_I2F = 2'b10, FP_MUL = 2'b11;

    function automatic logic is_rtype(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_FTYPE);
    endfunction

    function automatic ctrl_bundle_t dlx_decode(input logic [31:0] instr);
        ctrl_bundle_t c;
        logic [5:0]   op;
        logic [10:0]  fn;
        c  = '0;
        op = instr[31:26];
        fn = instr[10:0];
        if (is_rtype(op)) begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
            c.rd       = instr[15:11];
            c.rs1      = instr[20:16];
            c.rs2      = instr[25:21];
            case (fn)
                FN_SLL:              c.aluctrl = ALU_SLL;
                FN_SRL:              c.aluctrl = ALU_SRL;
                FN_SRA:              c.aluctrl = ALU_SRA;
                FN_ADD, FN_ADDU:     c.aluctrl = ALU_ADD;
                FN_SUB, FN_SUBU:     c.aluctrl = ALU_SUB;
                FN_AND:              c.aluctrl = ALU_AND;
                FN_OR:               c.aluctrl = ALU_OR;
                FN_XOR:              c.aluctrl = ALU_XOR;
                FN_SEQ:              c.aluctrl = ALU_SEQ;
                FN_SNE:              c.aluctrl = ALU_SNE;
                FN_SLT:              c.aluctrl = ALU_SLT;
                FN_SGT:              c.aluctrl = ALU_SGT;
                FN_SLE:              c.aluctrl = ALU_SLE;
                FN_SGE:              c.aluctrl = ALU_SGE;
                FN_MULT, FN_MULTU: begin
                    c.aluctrl = ALU_MUL;
                    c.fpoint  = FP_MUL;
                end
                FN_MOVFP2I: begin
                    c.aluctrl = ALU_ADD;
                    c.fpoint  = FP_F2I;
                end
                FN_MOVI2FP: begin
                    c.aluctrl = ALU_ADD;
                    c.fpoint  = FP_I2F;
                end
                FN_NOP:              c.regwrite = 1'b0;
                default:             c.aluctrl = ALU_AND;
            endcase
        end else if (op == OP_J || op == OP_JAL) begin
            c.jump = 1'b1;
        end else begin
            c.rd       = instr[20:16];
            c.rs1      = instr[25:21];
            c.alusrc   = 1'b1;
            c.regwrite = 1'b1;
            c.extop    = 1'b1;
            case (op)
                OP_ADDI:                            c.aluctrl = ALU_ADD;
                OP_SUBI:                            c.aluctrl = ALU_SUB;
                OP_ADDUI: begin c.aluctrl = ALU_ADD; c.extop = 1'b0; end
                OP_SUBUI: begin c.aluctrl = ALU_SUB; c.extop = 1'b0; end
                OP_ANDI:  begin c.aluctrl = ALU_AND; c.extop = 1'b0; end
                OP_ORI:   begin c.aluctrl = ALU_OR;  c.extop = 1'b0; end
                OP_XORI:  begin c.aluctrl = ALU_XOR; c.extop = 1'b0; end
                OP_SLLI:                            c.aluctrl = ALU_SLL;
                OP_SRLI:                            c.aluctrl = ALU_SRL;
                OP_SRAI:                            c.aluctrl = ALU_SRA;
                OP_SEQI:                            c.aluctrl = ALU_SEQ;
                OP_SNEI:                            c.aluctrl = ALU_SNE;
                OP_SLTI:                            c.aluctrl = ALU_SLT;
                OP_SGTI:                            c.aluctrl = ALU_SGT;
                OP_SLEI:                            c.aluctrl = ALU_SLE;
                OP_SGEI:                            c.aluctrl = ALU_SGE;
                OP_LHI, OP_LB, OP_LH, OP_LF, OP_LW: begin
                    c.aluctrl = ALU_ADD;
                    c.mem2reg = 1'b1;
                end
                OP_LBU, OP_LHU: begin
                    c.aluctrl = ALU_ADD;
                    c.mem2reg = 1'b1;
                    c.extop   = 1'b0;
                end
                OP_SB, OP_SH, OP_SW: begin
                    c.aluctrl  = ALU_ADD;
                    c.memwrite = 1'b1;
                    c.regwrite = 1'b0;
                end
                // Branches compare through the ALU and never write a register.
                OP_BEQZ, OP_BNEZ: begin
                    c.aluctrl  = ALU_SUB;
                    c.branch   = 1'b1;
                    c.alusrc   = 1'b0;
                    c.regwrite = 1'b0;
                end
                default:                            c.aluctrl = ALU_AND;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/dlx_decode_pipe_mul_hold.sv
// rtl/dlx_decode_pipe_mul_hold.sv - issue hold counter covering the multiplier latency
module dlx_mul_hold
    import dlx_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic flush,
    output logic busy
);

    localparam logic [3:0] HOLD_CYC = 4'(MUL_LAT - 1);

    mul_state_t state;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (MUL_LAT > 1)) begin
                        cnt   <= HOLD_CYC;
                        state <= MUL_WAIT;
                    end
                end
                MUL_WAIT: begin
                    // Leaving on the 1->0 step keeps busy high for exactly MUL_LAT-1 cycles.
                    if (cnt <= 4'd1) begin
                        cnt   <= 4'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign busy = (state == MUL_WAIT);

endmodule

// File: rtl/dlx_decode_pipe.sv
// rtl/dlx_decode_pipe.sv - registered DLX decode stage with ID/EX handshake, load-use and multiply holds
module dlx_decode_pipe
    import dlx_ctrl_pkg::*;
#(
    parameter int MUL_LAT   = 4,
    parameter int HAZARD_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic        flush,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic        ex_regdst,
    output logic        ex_alusrc,
    output logic        ex_mem2reg,
    output logic        ex_regwrite,
    output logic        ex_memwrite,
    output logic        ex_branch,
    output logic        ex_jump,
    output logic        ex_extop,
    output logic [1:0]  ex_fpoint,
    output logic [3:0]  ex_aluctrl,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        mul_busy
);

    ctrl_bundle_t dec;
    ctrl_bundle_t ex_q;
    logic         adv;
    logic         haz;
    logic         accept;

    assign dec = dlx_decode(if_instr);
    assign adv = !ex_valid || ex_ready;

    // rs2 only names a real source operand for R-type instructions.
    assign haz = (HAZARD_EN != 0) && ex_valid && ex_q.mem2reg && (ex_q.rd != 5'd0) &&
                 ((ex_q.rd == dec.rs1) || (is_rtype(if_instr[31:26]) && (ex_q.rd == dec.rs2)));

    assign if_ready = rst_n && !flush && adv && !haz && !mul_busy;
    assign accept   = if_valid && if_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_q     <= dec;
        end else if (adv) begin
            ex_valid <= 1'b0;
        end
    end

    dlx_mul_hold #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .start (accept && (dec.fpoint == FP_MUL)),
        .flush (flush),
        .busy  (mul_busy)
    );

    assign ex_regdst   = ex_q.regdst;
    assign ex_alusrc   = ex_q.alusrc;
    assign ex_mem2reg  = ex_q.mem2reg;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_memwrite = ex_q.memwrite;
    assign ex_branch   = ex_q.branch;
    assign ex_jump     = ex_q.jump;
    assign ex_extop    = ex_q.extop;
    assign ex_fpoint   = ex_q.fpoint;
    assign ex_aluctrl  = ex_q.aluctrl;
    assign ex_rd       = ex_q.rd;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;

endmodule

// File: doc/dlx_decode_pipe.md
# dlx_decode_pipe

Registered, pipelined successor to the single-cycle DLX control decoder. It sits between fetch (IF) and execute (EX) and decodes one 32-bit DLX instruction per cycle into the team's standard control bundle. It holds the bundle in an ID/EX register with a valid/ready handshake on both sides. It also inserts load-use bubbles, holds issue for a parametrised multiplier latency, and honours branch/jump flushes.

## Interface
Clock is `clk`. Reset is `rst_n`: asynchronous, active-low.

Parameters:
- `MUL_LAT`, default 4: EX cycles occupied by `mult`/`multu`. Legal range 1..15; 1 means no hold.
- `HAZARD_EN`, default 1: 1 enables load-use bubble insertion; 0 makes the hazard term constant 0.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset
- `if_valid`  in  1  fetch presents `if_instr`
- `if_ready`  out  1  block accepts `if_instr` this cycle
- `if_instr`  in  32  instruction word
- `flush`  in  1  kill the held ID/EX entry and the current input
- `ex_valid`  out  1  ID/EX entry valid
- `ex_ready`  in  1  EX consumes the entry
- `ex_regdst`, `ex_alusrc`, `ex_mem2reg`, `ex_regwrite`, `ex_memwrite`, `ex_branch`, `ex_jump`, `ex_extop`  out  1 each  registered control bits
- `ex_fpoint`  out  2  00 none, 01 fp→int, 10 int→fp, 11 multiply
- `ex_aluctrl`  out  4  ALU operation
- `ex_rd`, `ex_rs1`, `ex_rs2`  out  5 each  register specifiers
- `mul_busy`  out  1  multiplier hold active

## Operation
Decode (combinational, in package function `dlx_decode`):
- **R-type, opcode 0/1:** rd=[15:11], rs1=[20:16], rs2=[25:21]; regdst=1, regwrite=1; ALU op comes from func[10:0].
- **j/jal, opcode 2/3:** jump=1; all other control bits 0; specifiers 0.
- **I-type, all other opcodes:** rd=[20:16], rs1=[25:21], rs2=0; alusrc=1, extop=1 except the unsigned and logical ops.
- **Loads, 32–37 and 15:** mem2reg=1.
- **Stores, 40/41/43:** memwrite=1, regwrite=0.
- **Branches, 4/5:** branch=1, alusrc=0, aluctrl SUB.
- **nop, func 21:** regwrite=0. It is still a valid entry.
- **Unknown func/opcode:** aluctrl=0000. Other bits take their class defaults.

ALU codes: AND 0000, OR 0001, XOR 0010, ADD 0011, SUB 0100, MUL 0101, SEQ 0110, SNE 0111, SGE 1000, SGT 1001, SLT 1010, SLE 1011, SLL 1100, SRL 1101, SRA 1110.

Control terms:
- `adv` = !ex_valid || ex_ready
- `haz` = HAZARD_EN && ex_valid && ex_mem2reg && ex_rd≠0 && (ex_rd==dec.rs1 || (R-type && ex_rd==dec.rs2))
- `if_ready` = rst_n && !flush && adv && !haz && !mul_busy

Register update, first matching rule wins:
1. `flush`: ex_valid←0, multiplier counter←0.
2. `if_valid && if_ready`: load the decoded bundle, ex_valid←1.
3. `adv`: ex_valid←0. This is a bubble; the bundle fields may hold their old values.
4. Otherwise hold.

Multiplier FSM:
- **IDLE:** on accepting an instruction with fpoint=11 and MUL_LAT>1, cnt←MUL_LAT−1 and go to MUL_WAIT.
- **MUL_WAIT:** cnt decrements every cycle. When cnt reaches 0, return to IDLE.
- `mul_busy` = (state==MUL_WAIT).
- A `flush` in MUL_WAIT returns to IDLE immediately.

## Timing
- Latency: an instruction accepted at edge N shows on the ex_* outputs after edge N, i.e. one cycle.
- Throughput: one instruction per cycle with no hazard and ex_ready=1.
- Load-use: exactly one bubble cycle, because after the bubble the load has left the ID/EX register.
- Multiply: `if_ready` stays low for MUL_LAT−1 cycles after the mult is accepted.
- EX back-pressure (ex_valid=1, ex_ready=0): outputs are stable and unchanged, and `if_ready`=0.
- Reset (asynchronous, mid-operation included): every ex_* output is 0, ex_valid=0, mul_busy=0, FSM in IDLE, and `if_ready`=0 while `rst_n` is low.
- `flush` with `if_valid` in the same cycle: the input is not accepted.

## Structure
- Package `dlx_ctrl_pkg` holds:
  - the `ctrl_bundle_t` struct;
  - opcode and func localparams;
  - ALU code localparams;
  - the `dlx_decode` function.
- Sub-module `dlx_mul_hold`: counter plus FSM, with inputs `start`/`flush` and output `busy`.

## Test plan
- **Throughput:** stream addi (0x20410005) then or (0x00432025) with ex_ready=1. Expect ex_valid=1 on consecutive cycles, ex_aluctrl 0011 then 0001, ex_alusrc 1 then 0.
- **Load-use:** lw r3,0(r1) (0x8C230000) then add r4,r3,r2 (0x00432020). Expect one cycle with ex_valid=0 and if_ready=0, then the add issues with ex_rd=4. Repeat with HAZARD_EN=0: no bubble.
- **Multiply hold:** with MUL_LAT=4, send mult func 14 (0x0043200E). Expect ex_fpoint=11, ex_aluctrl=0101, mul_busy=1 and if_ready=0 for 3 cycles.
- **Back-pressure:** hold ex_ready=0 for 5 cycles with if_valid=1. Expect ex_* stable, if_ready=0, and no instruction lost.
- **Flush:** assert flush while in MUL_WAIT with a valid entry held. Next cycle expect ex_valid=0, mul_busy=0, if_ready=1.
- **Reset:** assert rst_n=0 mid-stream. Expect all outputs 0 asynchronously; the first instruction after release decodes correctly.
